mlp_stream_loader: RTL and testbench

- Sequential front/back end for the combinational bespoke MLP classifier (`top`: packed `inp` in, class `out` out).
- Performs in hardware what the simulation bench does from a file: receives one feature per valid/ready beat and packs NUM_A features into the classifier input bus.
- Holds the vector stable for a fixed settle window, captures the class, and returns it on a valid/ready result handshake.

---
 rtl/mlp_stream_loader_if.sv | 34 +++
 rtl/mlp_stream_loader.sv | 142 ++++++++++++++
 tb/tb_mlp_stream_loader.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_stream_loader_if.sv
`default_nettype none
// ============================================================================
// mlp_stream_loader_if : feature stream, classifier bus and result handshake
// Revision: 1.0
// ============================================================================
interface mlp_stream_loader_if #(
    parameter int NUM_A    = 16,
    parameter int WIDTH_A  = 4,
    parameter int OUTWIDTH = 4,
    parameter int COUNT_W  = 16
);
    logic                       clr;
    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH_A-1:0]         in_data;
    logic [NUM_A*WIDTH_A-1:0]   inp_bus;
    logic [OUTWIDTH-1:0]        cls_in;
    logic                       res_valid;
    logic                       res_ready;
    logic [OUTWIDTH-1:0]        res_class;
    logic                       busy;
    logic [COUNT_W-1:0]         vec_count;

    modport master (
        output clr, in_valid, in_data, cls_in, res_ready,
        input  in_ready, inp_bus, res_valid, res_class, busy, vec_count
    );

    modport slave (
        input  clr, in_valid, in_data, cls_in, res_ready,
        output in_ready, inp_bus, res_valid, res_class, busy, vec_count
    );
endinterface
`default_nettype wire

// File: rtl/mlp_stream_loader.sv
`default_nettype none
// ============================================================================
// mlp_stream_loader : packs streamed features for the MLP classifier, waits a
// settle window, captures the class and returns it on a result handshake.
// Revision: 1.0
// ============================================================================
module mlp_stream_loader #(
    parameter int NUM_A         = 16,
    parameter int WIDTH_A       = 4,
    parameter int OUTWIDTH      = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int COUNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mlp_stream_loader_if.slave    bus
);
    localparam int IDX_W = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(NUM_A - 1);
    localparam logic [7:0]       C_SETTLE_LD = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [IDX_W-1:0]           r_idx;
    logic [7:0]                 r_settle_cnt;
    logic [NUM_A*WIDTH_A-1:0]   r_inp_bus;
    logic [OUTWIDTH-1:0]        r_res_class;
    logic                       r_res_valid;
    logic [COUNT_W-1:0]         r_vec_count;
    logic                       w_in_ready;
    logic                       w_accept;
    logic                       w_slot_we;
    logic                       w_consume;

    // Gating with rst_n keeps the upstream from seeing a ready it cannot use.
    assign w_in_ready = (r_state == ST_LOAD) && rst_n;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_slot_we  = w_accept && !bus.clr;
    assign w_consume  = r_res_valid && bus.res_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_accept && (r_idx == C_LAST_IDX)) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_settle_cnt == 8'd0) begin
                    w_state_nxt = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (w_consume) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: w_state_nxt = ST_LOAD;
        endcase
        if (bus.clr) begin
            w_state_nxt = ST_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_settle_cnt <= 8'd0;
            r_res_class  <= '0;
            r_res_valid  <= 1'b0;
            r_vec_count  <= '0;
        end else if (bus.clr) begin
            r_idx       <= '0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        if (r_idx == C_LAST_IDX) begin
                            r_idx        <= '0;
                            r_settle_cnt <= C_SETTLE_LD;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == 8'd0) begin
                        r_res_class <= bus.cls_in;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 8'd1;
                    end
                end
                ST_RESULT: begin
                    if (w_consume) begin
                        r_res_valid <= 1'b0;
                        r_vec_count <= r_vec_count + COUNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Each slot only loads on its own index; untouched slots hold old data.
    generate
        for (genvar i = 0; i < NUM_A; i++) begin : g_slot
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_inp_bus[i*WIDTH_A +: WIDTH_A] <= '0;
                end else if (w_slot_we && (r_idx == IDX_W'(i))) begin
                    r_inp_bus[i*WIDTH_A +: WIDTH_A] <= bus.in_data;
                end
            end
        end
    endgenerate

    assign bus.in_ready  = w_in_ready;
    assign bus.inp_bus   = r_inp_bus;
    assign bus.res_valid = r_res_valid;
    assign bus.res_class = r_res_class;
    assign bus.vec_count = r_vec_count;
    assign bus.busy      = (r_state != ST_LOAD) || (r_idx != '0);

endmodule
`default_nettype wire

// File: tb/tb_mlp_stream_loader.sv
`default_nettype none
// ============================================================================
// tb_mlp_stream_loader : directed/random bench over two loader configurations
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mlp_stream_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, clr, in_valid, res_ready, sel;
    logic [3:0] in_data;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mlp_stream_loader_if #(.NUM_A(16), .WIDTH_A(4), .OUTWIDTH(4), .COUNT_W(16)) ifa ();
    mlp_stream_loader_if #(.NUM_A(16), .WIDTH_A(4), .OUTWIDTH(4), .COUNT_W(2))  ifb ();

    assign ifa.clr       = clr & ~sel;
    assign ifa.in_valid  = in_valid & ~sel;
    assign ifa.in_data   = in_data;
    assign ifa.res_ready = res_ready & ~sel;
    assign ifa.cls_in    = ifa.inp_bus[3:0] ^ ifa.inp_bus[63:60];
    assign ifb.clr       = clr & sel;
    assign ifb.in_valid  = in_valid & sel;
    assign ifb.in_data   = in_data;
    assign ifb.res_ready = res_ready & sel;
    assign ifb.cls_in    = ifb.inp_bus[3:0] ^ ifb.inp_bus[63:60];

    mlp_stream_loader #(.SETTLE_CYCLES(4), .COUNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    mlp_stream_loader #(.SETTLE_CYCLES(1), .COUNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    logic        m_in_ready, m_res_valid, m_busy;
    logic [63:0] m_inp_bus;
    logic [3:0]  m_res_class;
    logic [15:0] m_vec_count;
    assign m_in_ready  = sel ? ifb.in_ready  : ifa.in_ready;
    assign m_res_valid = sel ? ifb.res_valid : ifa.res_valid;
    assign m_busy      = sel ? ifb.busy      : ifa.busy;
    assign m_inp_bus   = sel ? ifb.inp_bus   : ifa.inp_bus;
    assign m_res_class = sel ? ifb.res_class : ifa.res_class;
    assign m_vec_count = sel ? {14'd0, ifb.vec_count} : ifa.vec_count;

    // Reference model: per-configuration vector image, slot pointer, result count.
    logic [63:0] mbus [2];
    int          midx [2];
    int          mcnt [2];
    int          last_acc;

    function automatic int settle_of(input logic s);
        return s ? 1 : 4;
    endfunction
    function automatic int mod_of(input logic s);
        return s ? 4 : 65536;
    endfunction
    function automatic logic [3:0] cls_of(input logic [63:0] v);
        return v[3:0] ^ v[63:60];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mbus[i] = 64'd0;
            midx[i] = 0;
            mcnt[i] = 0;
        end
    endtask

    task automatic push(input logic [3:0] d, input int gap);
        int t;
        repeat (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        while (m_in_ready !== 1'b1 && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (t >= 64) check("accept_timeout", 64'(t), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        last_acc = cyc;
        mbus[sel][midx[sel]*4 +: 4] = d;
        midx[sel] = (midx[sel] + 1) % 16;
    endtask

    task automatic push_vec(input logic [63:0] v, input int gapmax);
        for (int i = 0; i < 16; i++) push(v[i*4 +: 4], $urandom_range(0, gapmax));
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (m_res_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("settle_latency", 64'(n), 64'(settle_of(sel)));
        check("inp_bus", m_inp_bus, mbus[sel]);
        check("res_class", 64'(m_res_class), 64'(cls_of(mbus[sel])));
        check("busy_result", 64'(m_busy), 64'd1);
        check("in_ready_result", 64'(m_in_ready), 64'd0);
    endtask

    task automatic consume(input int hold);
        logic [3:0] held_cls;
        held_cls = m_res_class;
        res_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(m_res_valid), 64'd1);
            check("hold_class", 64'(m_res_class), 64'(held_cls));
            check("hold_in_ready", 64'(m_in_ready), 64'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        mcnt[sel] = (mcnt[sel] + 1) % mod_of(sel);
        check("res_valid_drop", 64'(m_res_valid), 64'd0);
        check("vec_count", 64'(m_vec_count), 64'(mcnt[sel]));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        check("rst_res_valid", 64'(m_res_valid), 64'd0);
        check("rst_inp_bus", m_inp_bus, 64'd0);
        check("rst_vec_count", 64'(m_vec_count), 64'd0);
        check("rst_in_ready_low", 64'(m_in_ready), 64'd0);
        check("rst_busy", 64'(m_busy), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready_back", 64'(m_in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        int          acc0, acc1;
        sel = 1'b0; rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
        res_ready = 1'b0; in_data = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Ascending features back to back.
        for (int i = 0; i < 16; i++) push(4'(i), 0);
        wait_result();
        check("ascending_bus", m_inp_bus, 64'hFEDCBA9876543210);
        check("ascending_class", 64'(m_res_class), 64'hF);
        consume(0);
        check("first_count", 64'(m_vec_count), 64'd1);

        // Random gaps, result back-pressure, then an all-5 vector.
        v = {$urandom, $urandom};
        push_vec(v, 3);
        wait_result();
        consume(10);
        push_vec({16{4'h5}}, 2);
        wait_result();
        check("all5_class", 64'(m_res_class), 64'd0);
        consume(0);

        // Abort after 7 features with a coincident beat.
        for (int i = 0; i < 7; i++) push(4'($urandom), 0);
        in_valid = 1'b1; in_data = 4'h9; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        midx[sel] = 0;
        check("clr_busy", 64'(m_busy), 64'd0);
        check("clr_in_ready", 64'(m_in_ready), 64'd1);
        check("clr_bus_kept", m_inp_bus, mbus[sel]);
        v = {$urandom, $urandom};
        push_vec(v, 1);
        wait_result();
        consume(0);
        repeat (30) @(negedge clk);
        check("single_result", 64'(m_res_valid), 64'd0);
        check("single_count", 64'(m_vec_count), 64'(mcnt[sel]));

        // Abort of a pending result that is being consumed at the same edge.
        push_vec({$urandom, $urandom}, 1);
        wait_result();
        clr = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        clr = 1'b0; res_ready = 1'b0;
        check("clr_drop_valid", 64'(m_res_valid), 64'd0);
        check("clr_no_count", 64'(m_vec_count), 64'(mcnt[sel]));
        check("clr_keep_class", 64'(m_res_class), 64'(cls_of(mbus[sel])));
        check("clr_keep_bus", m_inp_bus, mbus[sel]);

        // Reset during SETTLE, then during RESULT.
        push_vec({$urandom, $urandom}, 0);
        do_reset();
        repeat (10) @(negedge clk);
        check("no_spurious_valid", 64'(m_res_valid), 64'd0);
        push_vec({$urandom, $urandom}, 1);
        wait_result();
        do_reset();
        repeat (5) @(negedge clk);
        check("no_spurious_valid2", 64'(m_res_valid), 64'd0);

        // Short settle window and narrow counter.
        sel = 1'b1;
        #1;
        push_vec({$urandom, $urandom}, 2);
        wait_result();
        consume(0);
        res_ready = 1'b1;
        acc0 = 0; acc1 = 0;
        for (int i = 0; i < 32; i++) begin
            push(4'($urandom), 0);
            if (i == 0)  acc0 = last_acc;
            if (i == 15) mcnt[sel] = (mcnt[sel] + 1) % mod_of(sel);
            if (i == 16) begin
                acc1 = last_acc;
                check("count_seq_2", 64'(m_vec_count), 64'(mcnt[sel]));
            end
        end
        repeat (3) @(negedge clk);
        res_ready = 1'b0;
        mcnt[sel] = (mcnt[sel] + 1) % mod_of(sel);
        check("throughput", 64'(acc1 - acc0), 64'd18);
        check("count_seq_3", 64'(m_vec_count), 64'(mcnt[sel]));
        check("tp_bus", m_inp_bus, mbus[sel]);
        for (int k = 0; k < 2; k++) begin
            push_vec({$urandom, $urandom}, 1);
            wait_result();
            consume(0);
        end
        check("count_wrapped", 64'(m_vec_count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
